// File: rtl/shift_arb.sv
// -----------------------------------------------------------------------------
// shift_arb
//
// Round-robin arbiter in front of one shared 64-bit barrel shifter
// (SLL / SRL / SRA). At most one requester is granted per cycle. Its shift is
// computed combinationally and captured, together with the requester ID and an
// illegal-op flag, in a single-entry output register. Downstream drains that
// register through a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]      per-requester request valid
//   req_ready  [NREQ]      per-requester accept (one-hot or zero)
//   req_a      [NREQ*64]   operand A, requester i at [64i+63:64i]
//   req_shamt  [NREQ*6]    shift amount, requester i at [6i+5:6i]
//   req_op     [NREQ*2]    00 SLL, 01 SRL, 10 SRA, 11 illegal
//   res_valid              output register holds a result
//   res_ready              downstream accepts the result
//   res_data   [64]        shift result (0 for an illegal op)
//   res_id     [IDW]       index of the requester that produced res_data
//   res_err                the op was illegal
// -----------------------------------------------------------------------------
module shift_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*6-1:0]    req_shamt,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 res_err
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } shift_op_e;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_nxt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;
  logic              free;
  logic              xfer;
  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic [IDW:0]      cand;
  logic [63:0]       sel_a;
  logic [5:0]        sel_shamt;
  shift_op_e         sel_op;
  logic [63:0]       shift_res;

  // The slot can accept a new result if it is empty or being drained now.
  assign free = !res_valid || res_ready;
  assign xfer = free && gnt_any;

  // Rotate the request vector so that bit 0 is the requester named by ptr;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  // Doubling the vector makes the rotate work for any NREQ, not just powers
  // of two.
  assign dbl_valid = {req_valid, req_valid} >> ptr;
  assign rot_valid = dbl_valid[NREQ-1:0];

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    // Walk from the lowest priority down so the highest-priority hit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        cand    = {1'b0, ptr} + (IDW+1)'(k);
        if (cand >= NREQ_W) cand = cand - NREQ_W;
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Accept depends only on req_valid, ptr and the slot state; held low in
  // reset so nothing is offered while the block is being cleared.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && free && gnt_any && (gnt_idx == IDW'(i));
    end
  end

  assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a     = '0;
    sel_shamt = '0;
    sel_op    = OP_SLL;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a     = req_a[i*64 +: 64];
        sel_shamt = req_shamt[i*6 +: 6];
        sel_op    = shift_op_e'(req_op[i*2 +: 2]);
      end
    end
  end

  // Shared barrel shifter. shamt is 6 bits so it is already in 0..63.
  always_comb begin
    shift_res = '0;
    unique case (sel_op)
      OP_SLL:  shift_res = sel_a << sel_shamt;
      OP_SRL:  shift_res = sel_a >> sel_shamt;
      OP_SRA:  shift_res = $unsigned($signed(sel_a) >>> sel_shamt);
      default: shift_res = '0;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  // NOTE: the result payload is reset along with res_valid because the
  // cleared values are visible on the outputs, not just don't-care storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      // A grant in the same cycle as a drain simply replaces the old result.
      res_valid <= 1'b1;
      res_data  <= shift_res;
      res_id    <= gnt_idx;
      res_err   <= (sel_op == OP_ILL);
      ptr       <= ptr_nxt;
    end else if (res_ready) begin
      // Drain with no new grant: payload holds its last value.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arb.sv
// -----------------------------------------------------------------------------
// tb_shift_arb
//
// Self-checking bench for shift_arb (NREQ = 4). A behavioural model tracks the
// output register and round-robin pointer: arbitration picks the valid
// requester at the smallest circular distance from the pointer, and shifts are
// computed with multiply / divide by powers of two.
// -----------------------------------------------------------------------------
module tb_shift_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*64-1:0]  req_a;
  logic [NREQ*6-1:0]   req_shamt;
  logic [NREQ*2-1:0]   req_op;
  logic                res_valid;
  logic                res_ready;
  logic [63:0]         res_data;
  logic [IDW-1:0]      res_id;
  logic                res_err;

  shift_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_shamt (req_shamt),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  logic [63:0] m_data;
  int          m_id;
  bit          m_err;
  int          m_ptr;

  typedef struct {
    logic [63:0] a;
    logic [5:0]  sh;
    logic [1:0]  op;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];
  int   exp_order[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [63:0] a, input int sh, input int op);
    logic [127:0] p;
    logic [127:0] prod;
    p = 128'd1;
    for (int j = 0; j < sh; j++) p = p * 2;
    case (op)
      0: begin
        prod = {64'd0, a} * p;
        return prod[63:0];
      end
      1: return a / p[63:0];
      2: return a[63] ? ~((~a) / p[63:0]) : a / p[63:0];
      default: return 64'd0;
    endcase
  endfunction

  // Nearest valid requester at or after the pointer, if the slot is free.
  function automatic logic [NREQ-1:0] ref_ready();
    int best;
    int bestd;
    best  = -1;
    bestd = NREQ;
    if (rst || (m_valid && !res_ready)) return '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && ((i - m_ptr + NREQ) % NREQ) < bestd) begin
        bestd = (i - m_ptr + NREQ) % NREQ;
        best  = i;
      end
    end
    if (best < 0) return '0;
    return NREQ'(1) << best;
  endfunction

  task automatic model_clear();
    m_valid = 0;
    m_data  = '0;
    m_id    = 0;
    m_err   = 0;
    m_ptr   = 0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_res_valid"}, 64'(res_valid), 64'(m_valid));
    check({tag, "_res_data"},  res_data,       m_data);
    check({tag, "_res_id"},    64'(res_id),    64'(m_id));
    check({tag, "_res_err"},   64'(res_err),   64'(m_err));
    check({tag, "_ptr"},       64'(dut.ptr),   64'(m_ptr));
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [5:0] sh, input logic [1:0] op);
    req_valid[i]        = 1'b1;
    req_a[i*64 +: 64]   = a;
    req_shamt[i*6 +: 6] = sh;
    req_op[i*2 +: 2]    = op;
  endtask

  // Entered 1 time unit after a rising edge with inputs already driven.
  // Checks req_ready mid-cycle, advances the model at the edge, then checks
  // the registered outputs 1 unit after it.
  task automatic cycle(input string tag);
    logic [NREQ-1:0] er;
    int g;
    #1;
    er = ref_ready();
    check({tag, "_req_ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    g = -1;
    for (int i = 0; i < NREQ; i++) if (er[i]) g = i;
    if (g >= 0) begin
      m_valid = 1;
      m_data  = ref_shift(req_a[g*64 +: 64], int'(req_shamt[g*6 +: 6]), int'(req_op[g*2 +: 2]));
      m_id    = g;
      m_err   = (req_op[g*2 +: 2] == 2'b11);
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    model_clear();
    #1;
    check_outs("rst");
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] held_data;
  logic [IDW-1:0] held_id;

  initial begin
    vecs[0]  = '{64'hFFFF_0000_0000_0001, 6'd63, 2'b00, 64'h8000_0000_0000_0000, 1'b0};
    vecs[1]  = '{64'hFFFF_0000_0000_0001, 6'd63, 2'b01, 64'h0000_0000_0000_0001, 1'b0};
    vecs[2]  = '{64'hFFFF_0000_0000_0001, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[3]  = '{64'hFFFF_0000_0000_0001, 6'd0,  2'b00, 64'hFFFF_0000_0000_0001, 1'b0};
    vecs[4]  = '{64'hFFFF_0000_0000_0001, 6'd0,  2'b01, 64'hFFFF_0000_0000_0001, 1'b0};
    vecs[5]  = '{64'hFFFF_0000_0000_0001, 6'd0,  2'b10, 64'hFFFF_0000_0000_0001, 1'b0};
    vecs[6]  = '{64'h7FFF_FFFF_0000_0000, 6'd32, 2'b10, 64'h0000_0000_7FFF_FFFF, 1'b0};
    vecs[7]  = '{64'h8000_0000_0000_00F0, 6'd4,  2'b10, 64'hF800_0000_0000_000F, 1'b0};
    vecs[8]  = '{64'h1234_5678_9ABC_DEF0, 6'd7,  2'b11, 64'h0000_0000_0000_0000, 1'b1};
    vecs[9]  = '{64'h0000_0000_0000_0001, 6'd1,  2'b00, 64'h0000_0000_0000_0002, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 6'd4,  2'b01, 64'h0800_0000_0000_0000, 1'b0};
    exp_order = '{0, 1, 2, 3, 0};

    // Power-up reset: outputs cleared, nothing accepted while rst is high.
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_shamt = '0;
    req_op    = '0;
    res_ready = 1'b1;
    model_clear();
    #2;
    check_outs("por");
    req_valid = '1;
    #1;
    check("por_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    res_ready = 1'b0;
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single SRA request on requester 2.
    res_ready = 1'b1;
    set_req(2, 64'h8000_0000_0000_00F0, 6'd4, 2'b10);
    cycle("tp1");
    check("tp1_data", res_data, 64'hF800_0000_0000_000F);
    check("tp1_id", 64'(res_id), 64'd2);
    check("tp1_ptr", 64'(dut.ptr), 64'd3);
    req_valid = '0;

    // All four valid: round-robin order 0,1,2,3,0 at one result per cycle.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'h100 * (i + 1), 6'd1, 2'b00);
    for (int k = 0; k < 5; k++) begin
      cycle("rr");
      check("rr_order", 64'(res_id), 64'(exp_order[k]));
      check("rr_valid", 64'(res_valid), 64'd1);
    end
    check("rr_ptr_wrap", 64'(dut.ptr), 64'd1);

    // Backpressure with requesters 1 and 3 valid.
    req_valid = '0;
    set_req(1, 64'hDEAD_BEEF_0000_1111, 6'd8,  2'b01);
    set_req(3, 64'hCAFE_0000_F00D_0001, 6'd12, 2'b00);
    cycle("bp_fill");
    check("bp_fill_id", 64'(res_id), 64'd1);
    held_data = res_data;
    held_id   = res_id;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall");
      check("bp_req_ready_zero", 64'(req_ready), 64'd0);
      check("bp_data_stable", res_data, held_data);
      check("bp_id_stable", 64'(res_id), 64'(held_id));
    end
    res_ready = 1'b1;
    cycle("bp_resume");
    check("bp_resume_valid", 64'(res_valid), 64'd1);
    check("bp_resume_id", 64'(res_id), 64'd3);
    req_valid = '0;

    // Shift boundary table, applied through requester 0 alone.
    res_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      req_valid = '0;
      set_req(0, vecs[v].a, vecs[v].sh, vecs[v].op);
      cycle("vec");
      check($sformatf("vec%0d_data", v), res_data, vecs[v].exp_data);
      check($sformatf("vec%0d_err", v), 64'(res_err), 64'(vecs[v].exp_err));
    end
    req_valid = '0;

    // Illegal op from requester 0, then a legal follow-up.
    do_reset();
    res_ready = 1'b1;
    set_req(0, 64'h1234_5678_9ABC_DEF0, 6'd5, 2'b11);
    cycle("ill");
    check("ill_err", 64'(res_err), 64'd1);
    check("ill_data", res_data, 64'd0);
    check("ill_ptr", 64'(dut.ptr), 64'd1);
    set_req(0, 64'h0000_0000_0000_00F0, 6'd4, 2'b01);
    cycle("ill_next");
    check("ill_next_err", 64'(res_err), 64'd0);
    check("ill_next_data", res_data, 64'h0000_0000_0000_000F);
    req_valid = '0;

    // Asynchronous reset while a result is stalled.
    set_req(3, 64'h0000_00FF_0000_00FF, 6'd8, 2'b00);
    cycle("ar_fill");
    res_ready = 1'b0;
    req_valid = '0;
    cycle("ar_hold");
    check("ar_hold_valid", 64'(res_valid), 64'd1);
    #3;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'h55 + i, 6'd2, 2'b01);
    res_ready = 1'b1;
    rst       = 1'b1;
    model_clear();
    #1;
    check_outs("ar_async");
    check("ar_req_ready_in_rst", 64'(req_ready), 64'd0);
    #1;
    rst = 1'b0;
    cycle("ar_first");
    check("ar_first_id", 64'(res_id), 64'd0);
    req_valid = '0;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          set_req(i, {$urandom, $urandom}, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
